vx_execute_vec_sequencer: RTL and testbench
===========================================

# vx_execute_vec_sequencer

Sits between operand collection and the functional units. Expands each execute request into one or more execute beats, so vector instructions reach `NUM_LANES`-wide units as a sequence of register-group micro-ops. A scalar request passes through as a single beat. A vector request of length `vl` becomes `ceil(vl/NUM_LANES)` beats, each tagged with `vd`, `vd_lane_id`, `vd_is_last`, `sop`/`eop` and a per-beat lane mask.

## Interface
Parameters:
- `NUM_LANES`, 4: lanes per beat.
- `VLMAX_GROUPS`, 8: maximum beats per vector request.
- `NR_BITS`, 5: register index width.
- `PAYLOAD_W`, 256: opaque width of uuid/wid/PC/op_type/op_args/wb/rd/operand fields; passed through unchanged.
- `VL_BITS`, `$clog2(VLMAX_GROUPS*NUM_LANES)+1`: width of the vector length field.

Ports:
- `clk`, in, 1: clock.
- `reset_n`, in, 1: asynchronous active-low reset.
- `flush`, in, 1: synchronous drop of the current request and any pending beats.
- `in_valid`, in, 1: request valid.
- `in_ready`, out, 1: request accepted when `in_valid & in_ready`.
- `in_payload`, in, `PAYLOAD_W`: opaque request fields.
- `in_tmask`, in, `NUM_LANES`: thread mask.
- `in_is_vec`, in, 1: vector request.
- `in_vd`, in, `NR_BITS`: base vector destination register.
- `in_vl`, in, `VL_BITS`: element count; ignored when scalar.
- `out_valid`, out, 1: beat valid.
- `out_ready`, in, 1: beat consumed when `out_valid & out_ready`.
- `out_payload`, out, `PAYLOAD_W`: registered copy of `in_payload`.
- `out_tmask`, out, `NUM_LANES`: per-beat active lanes.
- `out_is_vec`, out, 1: registered copy of `in_is_vec`.
- `out_vd`, out, `NR_BITS`: destination register for this beat.
- `out_vd_lane_id`, out, `NR_BITS`: beat index b, zero-based.
- `out_vd_is_last`, out, 1: last beat of the request.
- `out_sop`, out, 1: first beat of the request.
- `out_eop`, out, 1: last beat of the request.
- `vl_clamp`, out, 1: one-cycle pulse when an accepted `in_vl` exceeded capacity.

## Operation
- FSM states:
  - IDLE: `out_valid`=0.
  - ISSUE: `out_valid`=1, beat b registered.
- Accept in IDLE moves to ISSUE with b=0. It latches payload, tmask, `is_vec`, `vd` and the effective vl (`vle`).
- Beat count N:
  - Scalar request: N=1.
  - Vector request: N=max(1, ceil(`vle`/NUM_LANES)).
  - `vle` = min(`in_vl`, VLMAX_GROUPS*NUM_LANES).
  - Any clamping asserts `vl_clamp` in the cycle after acceptance.
- Per-beat outputs:
  - `out_vd` = (vd + b) mod 2^NR_BITS; register wrap is permitted.
  - `out_vd_lane_id` = b.
  - `out_sop` = (b==0).
  - `out_eop` = `out_vd_is_last` = (b==N-1).
- Per-beat `out_tmask`:
  - Scalar: the latched tmask.
  - Vector, lane i: latched tmask[i] & (b*NUM_LANES+i < `vle`).
  - `vl`=0: exactly one beat with `out_tmask`=0 and `sop`=`eop`=`is_last`=1, so writeback accounting stays balanced.
- Beat handshake in ISSUE:
  - `out_valid & out_ready`, not the last beat: b increments.
  - Last beat consumed: returns to IDLE, or directly reloads if a new request is accepted the same cycle.
- `in_ready` = IDLE | (`out_valid` & `out_ready` & `out_eop`). Ignores `flush`: `flush` wins and any same-cycle accept is discarded.
- `flush`: next cycle IDLE, `out_valid`=0, `vl_clamp`=0, beat counter cleared.

## Timing
- Reset values: `out_valid`=0, `vl_clamp`=0, beat counter 0, all `out_*` data 0, state IDLE. `in_ready`=1 (combinational from IDLE).
- Latency: request accepted at edge T gives its first beat valid from T+1.
- Throughput: one beat per cycle with `out_ready` held high.
- Back-to-back scalars: one per cycle.
- Vector of N beats occupies N cycles; the next request's sop beat follows with no bubble.
- Stall (`out_valid` & !`out_ready`): all `out_*` held stable; `in_ready`=0 unless idle.
- Asynchronous `reset_n` assertion mid-sequence clears the state immediately. The first accept is possible at the first `clk` edge after deassertion.

## Test plan
- Scalar `in_tmask`=4'b1011, `in_vd`=3, `out_ready`=1 -> one beat at T+1: `sop`=`eop`=`is_last`=1, `lane_id`=0, `tmask`=4'b1011.
- Vector `vl`=10, `vd`=6, `tmask`=4'hF, NUM_LANES=4 -> 3 beats:
  - beat 0: `vd` 6, tmask F, `sop`=1.
  - beat 1: `vd` 7, tmask F.
  - beat 2: `vd` 8, tmask 4'b0011, `eop`=1.
  - next request's beat follows with no bubble.
- Vector `vl`=40, capacity 32 -> 8 beats, `vl_clamp` pulses once at T+1; `vd`=30 wraps to 31, 0, 1, …, 5.
- Vector `vl`=0 -> single beat with `tmask`=0, `sop`=`eop`=1; `out_ready` low for 3 cycles holds all outputs unchanged.
- `flush` asserted on beat 1 of a 4-beat request, together with `in_valid` -> next cycle `out_valid`=0 and the new request is not accepted; the following request issues normally.
- `reset_n` pulsed low on beat 2 (async, mid-cycle) -> outputs zero immediately; after release a scalar request issues at T+1.

Source files
------------

// File: rtl/vx_execute_vec_sequencer.sv
// Execute-request sequencer: expands each accepted request into one beat
// (scalar) or ceil(vl/NUM_LANES) register-group beats (vector), tagging each
// beat with destination register, beat index, sop/eop and a lane mask.
module vx_execute_vec_sequencer #(
    parameter int NUM_LANES    = 4,
    parameter int VLMAX_GROUPS = 8,
    parameter int NR_BITS      = 5,
    parameter int PAYLOAD_W    = 256,
    parameter int VL_BITS      = $clog2(VLMAX_GROUPS*NUM_LANES)+1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [NUM_LANES-1:0] in_tmask,
    input  logic                 in_is_vec,
    input  logic [NR_BITS-1:0]   in_vd,
    input  logic [VL_BITS-1:0]   in_vl,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [NUM_LANES-1:0] out_tmask,
    output logic                 out_is_vec,
    output logic [NR_BITS-1:0]   out_vd,
    output logic [NR_BITS-1:0]   out_vd_lane_id,
    output logic                 out_vd_is_last,
    output logic                 out_sop,
    output logic                 out_eop,
    output logic                 vl_clamp
);

    localparam int CAP    = VLMAX_GROUPS * NUM_LANES;
    localparam int BEAT_W = (VLMAX_GROUPS > 1) ? $clog2(VLMAX_GROUPS) : 1;
    localparam int CW     = VL_BITS + 1;
    localparam logic [VL_BITS-1:0] CAP_VL = VL_BITS'(CAP);

    typedef enum logic {ST_IDLE, ST_ISSUE} state_e;

    state_e                 state_q, state_d;
    logic [BEAT_W-1:0]      beat_q, beat_d;
    logic [BEAT_W-1:0]      last_q;
    logic [PAYLOAD_W-1:0]   payload_q;
    logic [NUM_LANES-1:0]   tmask_q;
    logic                   is_vec_q;
    logic [NR_BITS-1:0]     vd_q;
    logic [VL_BITS-1:0]     vle_q;
    logic                   clamp_q;

    logic                   load;
    logic                   fire;
    logic                   at_last;
    logic                   over_cap;
    logic [VL_BITS-1:0]     vle_in;
    logic [CW-1:0]          groups_in;
    logic [BEAT_W-1:0]      last_in;

    assign fire    = out_valid & out_ready;
    assign at_last = (beat_q == last_q);

    // Effective vl and index of the final beat for the incoming request
    always_comb begin
        over_cap  = (in_vl > CAP_VL);
        vle_in    = over_cap ? CAP_VL : in_vl;
        groups_in = ({1'b0, vle_in} + CW'(NUM_LANES - 1)) / CW'(NUM_LANES);
        last_in   = '0;
        if (in_is_vec && (groups_in != '0)) begin
            last_in = BEAT_W'(groups_in - CW'(1));
        end
    end

    // FSM state and beat counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // Next state, beat advance, accept decision; flush overrides everything
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        load     = 1'b0;
        in_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = ST_ISSUE;
                    beat_d  = '0;
                end
            end
            ST_ISSUE: begin
                if (fire) begin
                    if (at_last) begin
                        in_ready = 1'b1;
                        beat_d   = '0;
                        if (in_valid) begin
                            load = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
            beat_d  = '0;
            load    = 1'b0;
        end
    end

    // Request fields latched on accept; clamp flag pulses for one cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            payload_q <= '0;
            tmask_q   <= '0;
            is_vec_q  <= 1'b0;
            vd_q      <= '0;
            vle_q     <= '0;
            last_q    <= '0;
            clamp_q   <= 1'b0;
        end else begin
            clamp_q <= load & in_is_vec & over_cap;
            if (load) begin
                payload_q <= in_payload;
                tmask_q   <= in_tmask;
                is_vec_q  <= in_is_vec;
                vd_q      <= in_vd;
                vle_q     <= vle_in;
                last_q    <= last_in;
            end
        end
    end

    assign out_valid      = (state_q == ST_ISSUE);
    assign out_payload    = payload_q;
    assign out_is_vec     = is_vec_q;
    assign out_vd         = vd_q + NR_BITS'(beat_q);
    assign out_vd_lane_id = NR_BITS'(beat_q);
    assign out_sop        = out_valid & (beat_q == '0);
    assign out_eop        = out_valid & at_last;
    assign out_vd_is_last = out_eop;
    assign vl_clamp       = clamp_q;

    // Vector lanes beyond the effective vl are masked off in the tail beat
    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [CW-1:0] elem_idx;
            assign elem_idx      = CW'(beat_q) * CW'(NUM_LANES) + CW'(gi);
            assign out_tmask[gi] = tmask_q[gi] & (~is_vec_q | (elem_idx < {1'b0, vle_q}));
        end
    endgenerate

endmodule

// File: tb/tb_vx_execute_vec_sequencer.sv
// Bench for vx_execute_vec_sequencer: directed scenarios followed by random
// traffic, checked against a queue of expected beats built from the vl rules.
module tb_vx_execute_vec_sequencer;

    localparam int NL  = 4;
    localparam int NRB = 5;
    localparam int PW  = 256;
    localparam int VLB = 6;
    localparam int CAP = 32;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           flush = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [PW-1:0]  in_payload = '0;
    logic [NL-1:0]  in_tmask = '0;
    logic           in_is_vec = 1'b0;
    logic [NRB-1:0] in_vd = '0;
    logic [VLB-1:0] in_vl = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [PW-1:0]  out_payload;
    logic [NL-1:0]  out_tmask;
    logic           out_is_vec;
    logic [NRB-1:0] out_vd;
    logic [NRB-1:0] out_vd_lane_id;
    logic           out_vd_is_last;
    logic           out_sop;
    logic           out_eop;
    logic           vl_clamp;

    always #5 clk = ~clk;

    vx_execute_vec_sequencer dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload),
        .in_tmask(in_tmask), .in_is_vec(in_is_vec), .in_vd(in_vd), .in_vl(in_vl),
        .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
        .out_tmask(out_tmask), .out_is_vec(out_is_vec), .out_vd(out_vd),
        .out_vd_lane_id(out_vd_lane_id), .out_vd_is_last(out_vd_is_last),
        .out_sop(out_sop), .out_eop(out_eop), .vl_clamp(vl_clamp)
    );

    typedef struct {
        logic [PW-1:0]  payload;
        logic [NL-1:0]  tmask;
        logic           is_vec;
        logic [NRB-1:0] vd;
        logic [NRB-1:0] lane;
        logic           sop;
        logic           eop;
    } beat_t;

    beat_t exp_q[$];
    logic  clamp_exp = 1'b0;
    int    total = 0;
    int    passed = 0;
    int    failed = 0;

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic v, input logic [NRB-1:0] vd, input int vl, input logic [NL-1:0] tm);
        in_is_vec  = v;
        in_vd      = vd;
        in_vl      = VLB'(vl);
        in_tmask   = tm;
        in_payload = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    // Expected beat list for the request currently on the input pins
    task automatic push_request();
        int vle;
        int n;
        beat_t bt;
        vle = (int'(in_vl) > CAP) ? CAP : int'(in_vl);
        n   = in_is_vec ? (vle + NL - 1) / NL : 1;
        if (n == 0) n = 1;
        for (int b = 0; b < n; b++) begin
            bt.payload = in_payload;
            bt.is_vec  = in_is_vec;
            for (int i = 0; i < NL; i++)
                bt.tmask[i] = in_tmask[i] & (!in_is_vec || (b*NL + i < vle));
            bt.vd   = NRB'((int'(in_vd) + b) % 32);
            bt.lane = NRB'(b);
            bt.sop  = (b == 0);
            bt.eop  = (b == n - 1);
            exp_q.push_back(bt);
        end
    endtask

    // One cycle: drive inputs at the falling edge, check, update model, advance
    task automatic step(input logic v, input logic ordy, input logic fl);
        logic exp_rdy;
        logic fire;
        logic acc;
        in_valid  = v;
        out_ready = ordy;
        flush     = fl;
        #1;
        exp_rdy = (exp_q.size() == 0) || (ordy && exp_q.size() == 1);
        chk("out_valid", out_valid, exp_q.size() != 0);
        chk("in_ready", in_ready, exp_rdy);
        chk("vl_clamp", vl_clamp, clamp_exp);
        if (exp_q.size() != 0) begin
            chk("tmask", out_tmask, exp_q[0].tmask);
            chk("vd", out_vd, exp_q[0].vd);
            chk("lane_id", out_vd_lane_id, exp_q[0].lane);
            chk("sop", out_sop, exp_q[0].sop);
            chk("eop", out_eop, exp_q[0].eop);
            chk("is_last", out_vd_is_last, exp_q[0].eop);
            chk("payload", out_payload, exp_q[0].payload);
            chk("is_vec", out_is_vec, exp_q[0].is_vec);
        end
        fire = (exp_q.size() != 0) && ordy;
        acc  = exp_rdy && v && !fl;
        clamp_exp = 1'b0;
        if (fl) begin
            exp_q.delete();
        end else begin
            if (fire) void'(exp_q.pop_front());
            if (acc) begin
                push_request();
                clamp_exp = in_is_vec && (int'(in_vl) > CAP);
            end
        end
        @(negedge clk);
    endtask

    task automatic chk_zero_outputs(input string pfx);
        chk({pfx, "_out_valid"}, out_valid, 1'b0);
        chk({pfx, "_in_ready"}, in_ready, 1'b1);
        chk({pfx, "_vl_clamp"}, vl_clamp, 1'b0);
        chk({pfx, "_tmask"}, out_tmask, '0);
        chk({pfx, "_payload"}, out_payload, '0);
        chk({pfx, "_vd"}, out_vd, '0);
        chk({pfx, "_lane_id"}, out_vd_lane_id, '0);
        chk({pfx, "_sop"}, out_sop, 1'b0);
        chk({pfx, "_eop"}, out_eop, 1'b0);
    endtask

    initial begin
        // Reset values
        @(negedge clk);
        #1;
        chk_zero_outputs("reset");
        reset_n = 1'b1;

        // Scalar single beat
        set_req(1'b0, 5'd3, 0, 4'b1011);
        step(1, 1, 0);
        step(0, 1, 0);

        // Vector vl=10 -> 3 beats, then a scalar with no bubble
        set_req(1'b1, 5'd6, 10, 4'hF);
        step(1, 1, 0);
        step(0, 1, 0);
        step(0, 1, 0);
        set_req(1'b0, 5'd9, 0, 4'h5);
        step(1, 1, 0);
        step(0, 1, 0);

        // Vector vl=40 clamps to 8 beats, vd wraps from 30
        set_req(1'b1, 5'd30, 40, 4'hF);
        step(1, 1, 0);
        for (int k = 0; k < 8; k++) step(0, 1, 0);

        // vl=0 single empty beat held through a 3-cycle stall
        set_req(1'b1, 5'd2, 0, 4'hF);
        step(1, 1, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 1, 0);

        // Flush on beat 1 of a 4-beat request with a competing in_valid
        set_req(1'b1, 5'd1, 16, 4'hF);
        step(1, 1, 0);
        step(0, 1, 0);
        set_req(1'b0, 5'd12, 0, 4'hA);
        step(1, 1, 1);
        step(0, 1, 0);
        set_req(1'b0, 5'd13, 0, 4'h6);
        step(1, 1, 0);
        step(0, 1, 0);

        // Flush on a last beat where an accept would otherwise happen
        set_req(1'b0, 5'd14, 0, 4'h3);
        step(1, 1, 0);
        set_req(1'b1, 5'd15, 8, 4'hF);
        step(1, 1, 1);
        step(0, 1, 0);

        // Asynchronous reset mid-sequence on beat 2
        set_req(1'b1, 5'd4, 16, 4'hF);
        step(1, 1, 0);
        step(0, 1, 0);
        step(0, 1, 0);
        #3;
        reset_n = 1'b0;
        #1;
        chk_zero_outputs("async_rst");
        exp_q.delete();
        clamp_exp = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        set_req(1'b0, 5'd20, 0, 4'b0110);
        step(1, 1, 0);
        step(0, 1, 0);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            set_req(($urandom % 4) != 0, NRB'($urandom), int'($urandom_range(0, 45)), NL'($urandom));
            step(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 25) == 0);
        end
        for (int k = 0; k < 10; k++) step(0, 1, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
